hack_video_timing: RTL

Parametrised video timing generator and Hack screen scanner for the Nand2Tetris core. It generates the pixel clock enable, H/V counters, blanking and sync, and fetches 16-bit Hack screen words from screen RAM. Fetched words are serialised onto `vga_r/g/b`, with the Hack window placed inside a larger active raster and surrounded by a border colour. It sits inside `Nand2Tetris_top`, between the screen RAM read port and the emu video outputs.

---
 rtl/hack_video_timing.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/hack_video_timing.sv
// Hack screen scanner: CE_DIV pixel divider, H/V raster, 1-pixel output latency, free-running with no backpressure;
// screen RAM is read 2 clks ahead of each 16-pixel word. HACK_VIDEO_LINEDBL_EN shows every source row on two lines.
module hack_video_timing #(
  parameter int          CE_DIV     = 4,
  parameter int          H_ACTIVE   = 640,
  parameter int          H_FP       = 16,
  parameter int          H_SYNC     = 96,
  parameter int          H_BP       = 48,
  parameter int          V_ACTIVE   = 480,
  parameter int          V_FP       = 10,
  parameter int          V_SYNC     = 2,
  parameter int          V_BP       = 33,
  parameter bit          HS_POL     = 1'b0,
  parameter bit          VS_POL     = 1'b0,
  parameter int          WIN_X      = 64,
  parameter int          WIN_Y      = 112,
  parameter int          WIN_W      = 512,
  parameter int          WIN_H      = 256,
  parameter logic [23:0] BORDER_RGB = 24'h000000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        ce_pix,
  output logic        HBlank,
  output logic        VBlank,
  output logic        HSync,
  output logic        VSync,
  output logic [7:0]  vga_r,
  output logic [7:0]  vga_g,
  output logic [7:0]  vga_b,
  output logic [12:0] mem_addr,
  output logic        mem_rd,
  input  logic [15:0] mem_data,
  output logic        frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);
  localparam int DW      = $clog2(CE_DIV);
  localparam int WPR     = WIN_W / 16;
`ifdef HACK_VIDEO_LINEDBL_EN
  localparam int ROW_SHIFT = 1;
`else
  localparam int ROW_SHIFT = 0;
`endif
  localparam int WIN_LINES = WIN_H << ROW_SHIFT;

  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] hc_q, hc_d;
  logic [VW-1:0] vc_q, vc_d;
  logic          mem_rd_q, rd_pend_q;
  logic [12:0]   mem_addr_q, addr_d;
  logic [15:0]   word_buf_q;
  logic [14:0]   shift_q, shift_d;
  logic [23:0]   rgb_q, rgb_d;
  logic          hblank_q, vblank_q, hsync_q, vsync_q, frame_start_q;

  logic          ce, h_last, v_last, fetch_hit, win_px, act_px, pix_bit;
  logic [31:0]   hx, vy, hx_n, vy_n, f_col, row_n;
  logic [3:0]    win_ph;

  always_comb begin
    ce     = (div_q == DW'(CE_DIV - 1));
    div_d  = ce ? '0 : div_q + DW'(1);
    h_last = (hc_q == HW'(H_TOTAL - 1));
    v_last = (vc_q == VW'(V_TOTAL - 1));
    hc_d   = hc_q;
    vc_d   = vc_q;
    if (ce) begin
      hc_d = h_last ? '0 : hc_q + HW'(1);
      if (h_last) vc_d = v_last ? '0 : vc_q + VW'(1);
    end
    hx   = 32'(hc_q);
    vy   = 32'(vc_q);
    hx_n = 32'(hc_d);
    vy_n = 32'(vc_d);
  end

  // A fetch is launched as the raster steps onto the pixel just before each word,
  // so the row test uses the post-step line (matters when WIN_X-1 lands on column 0).
  always_comb begin
    f_col     = hx_n - 32'(WIN_X - 1);
    row_n     = (vy_n - 32'(WIN_Y)) >> ROW_SHIFT;
    fetch_hit = ce
             && (vy_n >= 32'(WIN_Y)) && (vy_n < 32'(WIN_Y + WIN_LINES))
             && (hx_n >= 32'(WIN_X - 1)) && (hx_n < 32'(WIN_X - 1 + WIN_W))
             && (f_col[3:0] == 4'd0);
    addr_d    = 13'(row_n * 32'(WPR) + (f_col >> 4));
  end

  always_comb begin
    act_px  = (hx < 32'(H_ACTIVE)) && (vy < 32'(V_ACTIVE));
    win_px  = (hx >= 32'(WIN_X)) && (hx < 32'(WIN_X + WIN_W))
           && (vy >= 32'(WIN_Y)) && (vy < 32'(WIN_Y + WIN_LINES));
    win_ph  = 4'(hx - 32'(WIN_X));
    pix_bit = 1'b0;
    shift_d = shift_q;
    rgb_d   = 24'h000000;
    if (win_px) begin
      if (win_ph == 4'd0) begin
        pix_bit = word_buf_q[0];
        shift_d = word_buf_q[15:1];
      end else begin
        pix_bit = shift_q[0];
        shift_d = {1'b0, shift_q[14:1]};
      end
      // Hack convention: a set bit is a black pixel.
      rgb_d = pix_bit ? 24'h000000 : 24'hFFFFFF;
    end else if (act_px) begin
      rgb_d = BORDER_RGB;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q         <= '0;
      hc_q          <= '0;
      vc_q          <= '0;
      mem_rd_q      <= 1'b0;
      mem_addr_q    <= '0;
      rd_pend_q     <= 1'b0;
      word_buf_q    <= '0;
      shift_q       <= '0;
      rgb_q         <= '0;
      hblank_q      <= 1'b1;
      vblank_q      <= 1'b1;
      hsync_q       <= ~HS_POL;
      vsync_q       <= ~VS_POL;
      frame_start_q <= 1'b0;
    end else begin
      div_q         <= div_d;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      mem_rd_q      <= fetch_hit;
      if (fetch_hit) mem_addr_q <= addr_d;
      rd_pend_q     <= mem_rd_q;
      if (rd_pend_q) word_buf_q <= mem_data;
      frame_start_q <= ce && h_last && v_last;
      if (ce) begin
        hblank_q <= (hx >= 32'(H_ACTIVE));
        vblank_q <= (vy >= 32'(V_ACTIVE));
        hsync_q  <= ((hx >= 32'(H_ACTIVE + H_FP)) && (hx < 32'(H_ACTIVE + H_FP + H_SYNC))) ? HS_POL : ~HS_POL;
        vsync_q  <= ((vy >= 32'(V_ACTIVE + V_FP)) && (vy < 32'(V_ACTIVE + V_FP + V_SYNC))) ? VS_POL : ~VS_POL;
        shift_q  <= shift_d;
        rgb_q    <= rgb_d;
      end
    end
  end

  assign ce_pix      = ce;
  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign HBlank      = hblank_q;
  assign VBlank      = vblank_q;
  assign HSync       = hsync_q;
  assign VSync       = vsync_q;
  assign frame_start = frame_start_q;
  assign vga_r       = rgb_q[23:16];
  assign vga_g       = rgb_q[15:8];
  assign vga_b       = rgb_q[7:0];

endmodule
